// File: rtl/ofdm_bit_group_ctrl.sv
// Sequencer for the mapper-feeding load/shift register: accepts bytes, emits 1/2/4/8-bit groups,
// and counts groups per OFDM symbol.
module ofdm_bit_group_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SYM_GROUPS = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] mod_sel,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] load_sel,
  output logic [3:0] shift_amt,
  output logic       byte_last,
  output logic       sym_last
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [1:0] LdHold  = 2'b00;
  localparam logic [1:0] LdLoad  = 2'b01;
  localparam logic [1:0] LdShift = 2'b10;

  state_e     state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] grp_cnt_q, grp_cnt_d;
  logic [3:0] k_new;
  logic       last_grp;

  assign k_new    = 4'd1 << mod_sel;
  assign last_grp = (bit_cnt_q + k_q) == 4'(DATA_W);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bit_cnt_d = bit_cnt_q;
    grp_cnt_d = grp_cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_sel  = LdHold;
    byte_last = 1'b0;
    sym_last  = 1'b0;
    shift_amt = 4'd0;
    // All outputs are forced low while reset is asserted.
    if (reset_n) begin
      shift_amt = k_q;
      unique case (state_q)
        StIdle: begin
          in_ready = 1'b1;
          if (in_valid) begin
            load_sel  = LdLoad;
            k_d       = k_new;
            bit_cnt_d = 4'd0;
            state_d   = StSend;
          end
        end
        StSend: begin
          out_valid = 1'b1;
          byte_last = last_grp;
          sym_last  = grp_cnt_q == 8'(SYM_GROUPS - 1);
          if (out_ready) begin
            grp_cnt_d = sym_last ? 8'd0 : grp_cnt_q + 8'd1;
            if (!last_grp) begin
              load_sel  = LdShift;
              bit_cnt_d = bit_cnt_q + k_q;
            end else begin
              // Last group: a waiting byte loads straight in, giving zero-bubble streaming.
              in_ready = 1'b1;
              if (in_valid) begin
                load_sel  = LdLoad;
                k_d       = k_new;
                bit_cnt_d = 4'd0;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      k_q       <= 4'd0;
      bit_cnt_q <= 4'd0;
      grp_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      bit_cnt_q <= bit_cnt_d;
      grp_cnt_q <= grp_cnt_d;
    end
  end

endmodule

// File: tb/tb_ofdm_bit_group_ctrl.sv
// Directed bench for ofdm_bit_group_ctrl: models the load/shift register and scores each group
// against an expected-group queue filled at byte accept.
module tb_ofdm_bit_group_ctrl;

  localparam int Sym = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] mod_sel = 2'b00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, byte_last, sym_last;
  logic [1:0] load_sel;
  logic [3:0] shift_amt;
  logic [7:0] reg_q;

  always #5 clk = ~clk;

  ofdm_bit_group_ctrl #(.DATA_W(8), .SYM_GROUPS(Sym)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mod_sel   (mod_sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .load_sel  (load_sel),
    .shift_amt (shift_amt),
    .byte_last (byte_last),
    .sym_last  (sym_last)
  );

  // External load/shift register driven by the controller.
  always @(posedge clk) begin
    if (!reset_n) reg_q <= 8'h00;
    else if (load_sel == 2'b01) reg_q <= in_data;
    else if (load_sel == 2'b10) reg_q <= reg_q << shift_amt;
  end

  typedef struct {
    logic [7:0] grp;
    int         k;
    logic       last;
  } grp_t;

  grp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  int   dut_sym = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [1:0] m);
    int k;
    logic [7:0] t;
    grp_t e;
    k = 1 << m;
    for (int i = 0; i < 8 / k; i++) begin
      t      = b << (i * k);
      e.grp  = t >> (8 - k);
      e.k    = k;
      e.last = (i == 8 / k - 1);
      sb.push_back(e);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check combinational outputs 1 time unit later.
  // exp_ls < 0 skips the load_sel check; exp_ls == 1 means the bench expects a byte accept.
  task automatic step(input logic rn, input logic iv, input logic [7:0] d, input logic [1:0] m,
                      input logic ordy, input int exp_ls);
    grp_t e;
    logic ev, es;
    @(negedge clk);
    reset_n = rn; in_valid = iv; in_data = d; mod_sel = m; out_ready = ordy;
    #1;
    if (!rn) begin
      chk("rst_load_sel", load_sel, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_byte_last", byte_last, 0);
      chk("rst_sym_last", sym_last, 0);
      chk("rst_shift_amt", shift_amt, 0);
      sb.delete();
      hs_cnt = 0;
    end else begin
      ev = (sb.size() != 0);
      chk("out_valid", out_valid, ev);
      if (exp_ls >= 0) chk("load_sel", load_sel, exp_ls);
      if (ev) begin
        e  = sb[0];
        es = (hs_cnt % Sym) == Sym - 1;
        chk("in_ready", in_ready, e.last && ordy);
        chk("shift_amt", shift_amt, e.k);
        chk("byte_last", byte_last, e.last);
        chk("sym_last", sym_last, es);
        chk("group", reg_q >> (8 - e.k), e.grp);
        if (ordy) begin
          void'(sb.pop_front());
          hs_cnt++;
          if (sym_last) dut_sym++;
        end
      end else begin
        chk("in_ready_idle", in_ready, 1);
      end
      if (exp_ls == 1) push_byte(d, m);
    end
  endtask

  initial begin
    int h;
    logic o;
    // Reset with inputs active: outputs must stay low.
    repeat (3) step(0, 1, 8'hFF, 2'b11, 1, -1);

    // QPSK 0xA5: groups 10,10,01,01.
    step(1, 1, 8'hA5, 2'b01, 1, 1);
    repeat (3) step(1, 0, 8'h00, 2'b01, 1, 2);
    step(1, 0, 8'h00, 2'b01, 1, 0);
    step(1, 0, 8'h00, 2'b01, 1, 0);

    // Back-to-back 16-QAM 0x3C, 0xF0 with in_valid held.
    step(1, 1, 8'h3C, 2'b10, 1, 1);
    step(1, 1, 8'hF0, 2'b10, 1, 2);
    step(1, 1, 8'hF0, 2'b10, 1, 1);
    step(1, 0, 8'h00, 2'b10, 1, 2);
    step(1, 0, 8'h00, 2'b10, 1, 0);
    step(1, 0, 8'h00, 2'b10, 0, 0);

    // Reset mid-SEND at bit_cnt=4.
    step(1, 1, 8'hC3, 2'b01, 1, 1);
    repeat (2) step(1, 0, 8'h00, 2'b01, 1, 2);
    repeat (3) step(0, 0, 8'h00, 2'b01, 1, -1);
    step(1, 0, 8'h00, 2'b01, 0, 0);

    // BPSK 0x81 with out_ready 1,0,0,1,...
    step(1, 1, 8'h81, 2'b00, 1, 1);
    h = 0;
    for (int i = 0; h < 8 && i < 40; i++) begin
      o = (i % 3 == 0);
      step(1, 0, 8'h00, 2'b00, o, !o ? 0 : (h == 7 ? 0 : 2));
      if (o) h++;
    end
    chk("bpsk_groups", h, 8);
    step(1, 0, 8'h00, 2'b00, 1, 0);

    // mod_sel change mid-byte is ignored; next byte goes out as one 8-bit group.
    step(1, 1, 8'h6C, 2'b01, 1, 1);
    step(1, 0, 8'h00, 2'b01, 1, 2);
    repeat (2) step(1, 0, 8'h00, 2'b11, 1, 2);
    step(1, 1, 8'h5A, 2'b11, 1, 1);
    step(1, 0, 8'h00, 2'b11, 1, 0);
    step(1, 0, 8'h00, 2'b11, 1, 0);

    // Symbol wrap with Sym=6: three QPSK bytes streamed back to back.
    step(0, 0, 8'h00, 2'b01, 1, -1);
    dut_sym = 0;
    step(1, 1, 8'h1B, 2'b01, 1, 1);
    repeat (3) step(1, 0, 8'h00, 2'b01, 1, 2);
    step(1, 1, 8'hE4, 2'b01, 1, 1);
    repeat (3) step(1, 0, 8'h00, 2'b01, 1, 2);
    step(1, 1, 8'h72, 2'b01, 1, 1);
    repeat (3) step(1, 0, 8'h00, 2'b01, 1, 2);
    step(1, 0, 8'h00, 2'b01, 1, 0);
    step(1, 0, 8'h00, 2'b01, 1, 0);
    chk("sym_last_count", dut_sym, 2);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ofdm_bit_group_ctrl.md
# ofdm_bit_group_ctrl

Sequencer for the 8-bit load/shift register that feeds the OFDM mapper. Accepts bytes from the scrambler/encoder over a valid/ready handshake and drives the register's 2-bit load select: load, shift or hold. It presents 1, 2, 4 or 8-bit groups (BPSK, QPSK, 16-QAM, 256-QAM) to the mapper under a second valid/ready handshake. It also counts groups per OFDM symbol and flags the symbol boundary.

## Interface
- DATA_W, 8: register width in bits; must be 8.
- SYM_GROUPS, 48: groups per OFDM symbol; range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  in  1  upstream byte available; the byte goes straight to the register's data input.
- in_ready  out  1  controller accepts a byte this cycle.
- mod_sel  in  2  00 BPSK (k=1), 01 QPSK (k=2), 10 16-QAM (k=4), 11 256-QAM (k=8); sampled only at byte accept.
- out_ready  in  1  mapper consumes the current group this cycle.
- out_valid  out  1  register MSBs [7:8-k] hold a valid group.
- load_sel  out  2  to register: 00 hold, 01 load data, 10 shift by shift_amt; 11 never driven.
- shift_amt  out  4  k for the current byte (1, 2, 4 or 8); also tells the mapper the group width.
- byte_last  out  1  current group is the last group of the byte.
- sym_last  out  1  current group is group SYM_GROUPS-1 of the symbol.

## Operation
- States: IDLE, SEND.
- Byte accept: a handshake is in_valid && in_ready.
- IDLE:
  - in_ready=1, out_valid=0.
  - load_sel=01 when in_valid, else 00.
  - On accept: latch k from mod_sel, bit_cnt←0, go to SEND.
- SEND:
  - out_valid=1; in_ready=0 except on the last group.
  - On a group handshake (out_ready=1):
    - Not the last group: load_sel=10, bit_cnt←bit_cnt+k.
    - Last group (bit_cnt+k==8): in_ready=1. If in_valid, load_sel=01, latch new k, bit_cnt←0 and stay in SEND. Otherwise load_sel=00 and go to IDLE.
  - No handshake (out_ready=0): load_sel=00 and all state holds.
- byte_last = (state==SEND) && (bit_cnt+k==8).
- Latching rules:
  - mod_sel changes mid-byte are ignored.
  - k=8 means a single group per byte; byte_last=1 for the whole SEND residency.
- bit_cnt is 4 bits wide. bit_cnt+k never exceeds 8, because k divides 8.
- Symbol counter grp_cnt, 8 bits:
  - Increments on each group handshake.
  - sym_last = (grp_cnt==SYM_GROUPS-1) && out_valid.
  - On a handshake with sym_last=1, grp_cnt wraps to 0.
  - The counter is independent of byte boundaries; a symbol may end mid-byte.
- load_sel, in_ready, byte_last and sym_last are combinational from state, counters, in_valid and out_ready. No combinational path runs from out_ready to out_valid.

## Timing
- Reset (reset_n=0 at an edge):
  - State←IDLE; bit_cnt, grp_cnt and k←0.
  - While reset_n=0: load_sel=00, out_valid=0, in_ready=0, byte_last=0, sym_last=0, shift_amt=0.
  - The register shares reset_n and clears in the same cycle.
- Reset mid-byte discards the remaining groups and restarts the symbol count.
- Latency: byte accepted at edge N; its first group is valid after edge N (out_valid high in cycle N+1).
- Throughput with out_ready held high: 8/k groups per byte and zero bubbles between back-to-back bytes.
  - BPSK: 8 groups per 8 cycles.
  - 256-QAM: 1 byte per cycle.
- If in_valid is low at the last group: one IDLE cycle minimum before the next byte's first group.
- Backpressure: while out_valid=1 and out_ready=0, the register contents, shift_amt, byte_last and sym_last must stay stable.
- Simultaneous events: a last-group handshake and a byte accept in the same cycle give load_sel=01, never 10.

## Test plan
- Reset: hold reset_n=0 for 3 cycles mid-SEND with bit_cnt=4 -> all outputs 0 and state IDLE. Next byte's first group has grp_cnt=0.
- QPSK: byte 0xA5 with out_ready=1 -> groups 10, 10, 01, 01 on consecutive cycles. load_sel sequence is 01, 10, 10, 10, then 00. byte_last only on the 4th group.
- Back-to-back 16-QAM: bytes 0x3C then 0xF0 with in_valid held -> groups 0011, 1100, 1111, 0000 with no gap. load_sel=01 on the 2nd group's handshake.
- Backpressure, BPSK: byte 0x81 with out_ready toggling 1,0,0,1… -> 8 groups 1,0,0,0,0,0,0,1. load_sel=00 and Q stable on every stalled cycle.
- Mode change mid-byte: mod_sel switches from 01 to 11 after the first QPSK group -> the byte finishes as 4 QPSK groups. The next byte goes out as one 8-bit group.
- Symbol wrap: SYM_GROUPS=6, QPSK with 3 bytes -> sym_last on groups 6 and 12. grp_cnt wraps, and a symbol boundary falls mid-byte.
